apb_slave_responder: RTL and testbench



---
 rtl/apb_global_pkg.sv | 16 +
 rtl/apb_slave_mem.sv | 28 ++
 rtl/apb_slave_responder.sv | 145 ++++++++++++++
 tb/tb_apb_slave_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_global_pkg.sv
// rtl/apb_global_pkg.sv - shared APB bus widths and transfer-state encoding
package apb_global_pkg;

  localparam int ADDRESS_LENGTH = 32;
  localparam int DATA_WIDTH     = 64;
  localparam int STRB_WIDTH     = DATA_WIDTH / 8;

  // SETUP_STATE exists so the encoding matches the master agent; the completer
  // treats setup as the IDLE cycle with pselx=1, penable=0 and never stores it.
  typedef enum logic [1:0] {
    IDLE_STATE   = 2'd0,
    SETUP_STATE  = 2'd1,
    ACCESS_STATE = 2'd2
  } operation_states_e;

endpackage

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - single-port word memory, byte-enabled sync write, comb read
module apb_slave_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte lanes with a strobe take new data; the rest keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (wstrb[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave_responder.sv
// rtl/apb_slave_responder.sv - APB completer with wait states, strobed writes and error decode
module apb_slave_responder #(
  parameter int ADDRESS_LENGTH = apb_global_pkg::ADDRESS_LENGTH,
  parameter int DATA_WIDTH     = apb_global_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH      = 256,
  parameter logic [ADDRESS_LENGTH-1:0] BASE_ADDR = '0
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      pselx,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_LENGTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [3:0]                wait_cycles,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr
);
  import apb_global_pkg::*;

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int OFS_LSB = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_LENGTH:0]   WIN_BYTES  = (ADDRESS_LENGTH+1)'(MEM_DEPTH * STRB_W);
  localparam logic [ADDRESS_LENGTH-1:0] ALIGN_MASK = ADDRESS_LENGTH'(STRB_W - 1);

  operation_states_e     state_q, state_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [ADDRESS_LENGTH-1:0] offset;
  logic                      dec_err;
  logic [IDX_W-1:0]          dec_idx;
  logic [IDX_W-1:0]          mem_addr;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      unused_pprot;

  assign unused_pprot = ^pprot;

  // Window decode: below base, past the end, or not word aligned is an error.
  assign offset  = paddr - BASE_ADDR;
  assign dec_err = (paddr < BASE_ADDR) || ({1'b0, offset} >= WIN_BYTES) || (|(paddr & ALIGN_MASK));
  assign dec_idx = IDX_W'(offset >> OFS_LSB);

  // Setup reads at the live address; the access phase uses the latched index.
  assign mem_addr = (state_q == ACCESS_STATE) ? idx_q : dec_idx;
  assign mem_we   = (state_q == ACCESS_STATE) && pready_q && pselx && penable && write_q && !err_q;

  apb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (pwdata),
    .wstrb (pstrb),
    .rdata (mem_rdata)
  );

  // Transfer sequencing: setup latch, wait-state countdown, completion or abort.
  always_comb begin
    state_d   = state_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    err_d     = err_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE_STATE: begin
        if (pselx && !penable) begin
          write_d = pwrite;
          err_d   = dec_err;
          idx_d   = dec_idx;
          cnt_d   = wait_cycles;
          state_d = ACCESS_STATE;
          if (wait_cycles == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            prdata_d  = (!pwrite && !dec_err) ? mem_rdata : '0;
          end
        end
      end
      ACCESS_STATE: begin
        if (!pselx || (pready_q && penable)) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
          cnt_d     = 4'd0;
          state_d   = IDLE_STATE;
        end else if (!pready_q) begin
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!write_q && !err_q) ? mem_rdata : '0;
            cnt_d     = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE_STATE;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= IDLE_STATE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_responder.sv
// tb/tb_apb_slave_responder.sv - scoreboard bench for apb_slave_responder
module tb_apb_slave_responder;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        pselx, penable, pwrite;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [2:0]  pprot;
  logic [3:0]  wait_cycles;
  logic        pready, pslverr;
  logic [63:0] prdata;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          wt;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model_mem [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  apb_slave_responder #(
    .ADDRESS_LENGTH (32),
    .DATA_WIDTH     (64),
    .MEM_DEPTH      (256),
    .BASE_ADDR      (32'h0)
  ) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .pselx       (pselx),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .wait_cycles (wait_cycles),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a >= 32'h800) || (a[2:0] != 3'd0);
  endfunction

  // One full transfer; the next call may start directly on the completion edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input logic [3:0] wt);
    exp_t e;
    int   waits;
    logic err;
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; wait_cycles = wt; pprot = 3'($urandom);
    err    = model_err(addr);
    e.err  = err;
    e.wt   = int'(wt);
    e.data = (!wr && !err) ? model_mem[addr[10:3]] : 64'h0;
    sb_q.push_back(e);
    @(negedge pclk);
    check_eq("setup_pready", {63'h0, pready}, 64'h0);
    @(posedge pclk); #1;
    penable = 1'b1;
    wait_cycles = 4'($urandom);
    waits = 0;
    @(negedge pclk);
    while (!pready && waits < 40) begin
      waits++;
      @(negedge pclk);
    end
    e = sb_q.pop_front();
    check_eq("pready_seen", {63'h0, pready}, 64'h1);
    check_eq("wait_states", 64'(waits), 64'(e.wt));
    check_eq("pslverr", {63'h0, pslverr}, {63'h0, e.err});
    check_eq("prdata", prdata, e.data);
    if (wr && !err) begin
      for (int b = 0; b < 8; b++) begin
        if (strb[b]) model_mem[addr[10:3]][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  task automatic go_idle();
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check_eq("idle_pready", {63'h0, pready}, 64'h0);
  endtask

  initial begin
    preset_n = 1'b0; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0; wait_cycles = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check_eq("rst_pready", {63'h0, pready}, 64'h0);
    check_eq("rst_pslverr", {63'h0, pslverr}, 64'h0);
    check_eq("rst_prdata", prdata, 64'h0);
    @(posedge pclk); #1;
    preset_n = 1'b1;

    // full write and readback, no wait states
    apb_xfer(1'b1, 32'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4'd0);
    go_idle();
    apb_xfer(1'b0, 32'h10, 64'h0, 8'h00, 4'd0);
    go_idle();

    // low-half strobed write
    apb_xfer(1'b1, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4'd0);
    go_idle();
    apb_xfer(1'b0, 32'h10, 64'h0, 8'hFF, 4'd0);
    check_eq("partial_write", prdata, 64'hDEAD_BEEF_FFFF_FFFF);
    go_idle();

    // three wait states
    apb_xfer(1'b0, 32'h10, 64'h0, 8'h00, 4'd3);
    go_idle();

    // misaligned and out-of-range accesses
    apb_xfer(1'b1, 32'h804, 64'h1111_2222_3333_4444, 8'hFF, 4'd1);
    apb_xfer(1'b1, 32'h800, 64'h5555_6666_7777_8888, 8'hFF, 4'd2);
    apb_xfer(1'b0, 32'h800, 64'h0, 8'h00, 4'd0);
    apb_xfer(1'b0, 32'h804, 64'h0, 8'h00, 4'd1);
    apb_xfer(1'b1, 32'h13, 64'h0, 8'hFF, 4'd0);
    apb_xfer(1'b0, 32'h10, 64'h0, 8'h00, 4'd0);
    go_idle();

    // back-to-back write then read
    apb_xfer(1'b1, 32'h08, 64'hCAFE_F00D_8BAD_F00D, 8'hFF, 4'd0);
    apb_xfer(1'b0, 32'h08, 64'h0, 8'h00, 4'd0);
    apb_xfer(1'b1, 32'h7F8, 64'h0123_4567_89AB_CDEF, 8'hF0, 4'd2);
    apb_xfer(1'b0, 32'h7F8, 64'h0, 8'h00, 4'd1);
    go_idle();

    // varied full-word transfers
    for (int i = 0; i < 6; i++) begin
      apb_xfer(1'b1, 32'h100 + 32'(i * 8), {$urandom, $urandom}, 8'hFF, 4'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 6; i++) begin
      apb_xfer(1'b0, 32'h100 + 32'(i * 8), 64'h0, 8'h00, 4'($urandom_range(0, 3)));
    end
    go_idle();

    // access phase without setup is ignored
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 64'h0; pstrb = 8'hFF;
    repeat (2) begin
      @(negedge pclk);
      check_eq("nosetup_pready", {63'h0, pready}, 64'h0);
    end
    go_idle();
    apb_xfer(1'b0, 32'h10, 64'h0, 8'h00, 4'd0);
    go_idle();

    // abort mid-wait by dropping pselx
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 64'hAAAA_AAAA_AAAA_AAAA; pstrb = 8'hFF; wait_cycles = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    pselx = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check_eq("abort_pready", {63'h0, pready}, 64'h0);
    check_eq("abort_pslverr", {63'h0, pslverr}, 64'h0);
    check_eq("abort_prdata", prdata, 64'h0);
    apb_xfer(1'b0, 32'h10, 64'h0, 8'h00, 4'd1);
    go_idle();

    // reset while pready is high, before the completion edge
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
    pwdata = 64'h5555_5555_5555_5555; pstrb = 8'hFF; wait_cycles = 4'd0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check_eq("pre_rst_pready", {63'h0, pready}, 64'h1);
    #1;
    preset_n = 1'b0;
    #1;
    check_eq("async_rst_pready", {63'h0, pready}, 64'h0);
    check_eq("async_rst_pslverr", {63'h0, pslverr}, 64'h0);
    check_eq("async_rst_prdata", prdata, 64'h0);
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0; preset_n = 1'b1;
    apb_xfer(1'b0, 32'h08, 64'h0, 8'h00, 4'd0);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
